dynamixel_status_parser: RTL and testbench



---
 rtl/dynamixel_status_parser.sv | 192 +++++++++++++++++++
 tb/tb_dynamixel_status_parser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamixel_status_parser.sv
// Dynamixel 2.0 status packet parser: header search, destuffing,
// length/instruction checks and CRC-16 verification of servo replies.
module dynamixel_status_parser #(
    parameter int unsigned max_length     = 16,
    parameter int unsigned timeout_clocks = 10000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        status_valid,
    output logic [7:0]  status_id,
    output logic [7:0]  status_error,
    output logic [31:0] status_data,
    output logic [7:0]  status_param_count,
    output logic        crc_error,
    output logic        frame_error
);

    localparam int TW = $clog2(timeout_clocks + 1);
    localparam logic [TW-1:0] TMAX = TW'(timeout_clocks - 1);

    typedef enum logic [3:0] {
        S_H1, S_H2, S_H3, S_RSV, S_ID, S_LEN_L,
        S_LEN_H, S_INSTR, S_ERR, S_PARAM, S_CRC_L, S_CRC_H
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   crc_q;
    logic [15:0]   crc_next;
    logic [15:0]   crc_first;
    logic [7:0]    id_q;
    logic [7:0]    err_q;
    logic [7:0]    len_l_q;
    logic [7:0]    rem_q;
    logic [7:0]    rem_dec;
    logic [7:0]    crc_l_q;
    logic [7:0]    cnt_q;
    logic [31:0]   data_q;
    logic [23:0]   track_q;
    logic [TW-1:0] timer_q;

    logic valid_d, crc_err_d, frame_err_d;
    logic timeout;
    logic len_ok;
    logic stuffed;
    logic crc_en;

    function automatic logic [15:0] crc16(input logic [15:0] c,
                                          input logic [7:0]  b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    assign crc_next  = crc16(crc_q, rx_byte);
    assign crc_first = crc16(16'h0000, rx_byte);
    assign rem_dec   = rem_q - 8'd1;
    assign stuffed   = (track_q == 24'hFFFFFD) && (rx_byte == 8'hFD);
    assign timeout   = !rx_valid && (state_q != S_H1) && (timer_q == TMAX);
    assign len_ok    = (rx_byte == 8'h00)
                    && (32'(len_l_q) >= 32'd4)
                    && (32'(len_l_q) <= 32'(max_length));

    // A repeated FF in H3 is just a longer preamble; the CRC keeps FF FF
    assign crc_en = (state_q inside {S_H2, S_RSV, S_ID, S_LEN_L, S_LEN_H,
                                     S_INSTR, S_ERR, S_PARAM})
                 || (state_q == S_H3 && rx_byte != 8'hFF);

    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                S_H1:    if (rx_byte == 8'hFF) state_d = S_H2;
                S_H2:    state_d = (rx_byte == 8'hFF) ? S_H3 : S_H1;
                S_H3: begin
                    if (rx_byte == 8'hFD)      state_d = S_RSV;
                    else if (rx_byte != 8'hFF) state_d = S_H1;
                end
                S_RSV:   state_d = (rx_byte == 8'h00) ? S_ID : S_H1;
                S_ID:    state_d = (rx_byte <= 8'hFC) ? S_LEN_L : S_H1;
                S_LEN_L: state_d = S_LEN_H;
                S_LEN_H: begin
                    if (len_ok) begin
                        state_d = S_INSTR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_H1;
                    end
                end
                S_INSTR: begin
                    if (rx_byte == 8'h55) begin
                        state_d = S_ERR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_H1;
                    end
                end
                S_ERR:   state_d = (rem_dec == 8'd2) ? S_CRC_L : S_PARAM;
                S_PARAM: if (rem_dec == 8'd2) state_d = S_CRC_L;
                S_CRC_L: state_d = S_CRC_H;
                S_CRC_H: begin
                    if ({rx_byte, crc_l_q} == crc_q) valid_d = 1'b1;
                    else crc_err_d = 1'b1;
                    state_d = S_H1;
                end
                default: state_d = S_H1;
            endcase
        end else if (timeout) begin
            frame_err_d = 1'b1;
            state_d     = S_H1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= S_H1;
            status_valid       <= 1'b0;
            crc_error          <= 1'b0;
            frame_error        <= 1'b0;
            status_id          <= '0;
            status_error       <= '0;
            status_data        <= '0;
            status_param_count <= '0;
            crc_q              <= '0;
            id_q               <= '0;
            err_q              <= '0;
            len_l_q            <= '0;
            rem_q              <= '0;
            crc_l_q            <= '0;
            cnt_q              <= '0;
            data_q             <= '0;
            track_q            <= '0;
            timer_q            <= '0;
        end else begin
            state_q     <= state_d;
            status_valid <= valid_d;
            crc_error   <= crc_err_d;
            frame_error <= frame_err_d;

            if (rx_valid || state_q == S_H1 || timeout) timer_q <= '0;
            else timer_q <= timer_q + 1'b1;

            if (valid_d) begin
                status_id          <= id_q;
                status_error       <= err_q;
                status_data        <= data_q;
                status_param_count <= cnt_q;
            end

            if (rx_valid) begin
                if (state_q == S_H1 && rx_byte == 8'hFF) begin
                    crc_q   <= crc_first;
                    cnt_q   <= '0;
                    data_q  <= '0;
                    track_q <= '0;
                end else if (crc_en) begin
                    crc_q <= crc_next;
                end
                unique case (state_q)
                    S_ID:    id_q    <= rx_byte;
                    S_LEN_L: len_l_q <= rx_byte;
                    S_LEN_H: rem_q   <= len_l_q;
                    S_INSTR: rem_q   <= rem_dec;
                    S_ERR: begin
                        err_q <= rx_byte;
                        rem_q <= rem_dec;
                    end
                    S_PARAM: begin
                        rem_q   <= rem_dec;
                        track_q <= {track_q[15:0], rx_byte};
                        if (!stuffed) begin
                            if (cnt_q < 8'd4)
                                data_q[{cnt_q[1:0], 3'b000} +: 8] <= rx_byte;
                            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_CRC_L: crc_l_q <= rx_byte;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dynamixel_status_parser.sv
// Scoreboard bench for dynamixel_status_parser: directed packets,
// expected pulses queued with their cycle and checked by a monitor.
module tb_dynamixel_status_parser;

    localparam int TMO = 20;

    logic        clock;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        status_valid;
    logic [7:0]  status_id;
    logic [7:0]  status_error;
    logic [31:0] status_data;
    logic [7:0]  status_param_count;
    logic        crc_error;
    logic        frame_error;

    dynamixel_status_parser #(
        .max_length(16),
        .timeout_clocks(TMO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .status_valid(status_valid),
        .status_id(status_id),
        .status_error(status_error),
        .status_data(status_data),
        .status_param_count(status_param_count),
        .crc_error(crc_error),
        .frame_error(frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  id;
        logic [7:0]  err;
        logic [31:0] data;
        logic [7:0]  cnt;
        int          cyc;
    } ev_t;

    localparam logic [2:0] K_OK  = 3'b001;
    localparam logic [2:0] K_CRC = 3'b010;
    localparam logic [2:0] K_FRM = 3'b100;

    ev_t         exp_q[$];
    logic [7:0]  tx[$];
    int          cyc;
    int          pass_n;
    int          total_n;
    int          npulse;
    ev_t         e;
    logic [7:0]  h_id, h_err, h_cnt;
    logic [31:0] h_data;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                if (c[15] ^ b[i][k]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic send_tx();
        foreach (tx[i]) begin
            rx_valid = 1'b1;
            rx_byte  = tx[i];
            @(posedge clock);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_ev(input logic [2:0] kind, input int at);
        ev_t x;
        x.kind = kind;
        x.id   = h_id;
        x.err  = h_err;
        x.data = h_data;
        x.cnt  = h_cnt;
        x.cyc  = at;
        exp_q.push_back(x);
    endtask

    task automatic push_ok(input logic [7:0] id, input logic [7:0] err,
                           input logic [31:0] data, input logic [7:0] cnt);
        h_id   = id;
        h_err  = err;
        h_data = data;
        h_cnt  = cnt;
        push_ev(K_OK, cyc);
    endtask

    task automatic load_ping();
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00,
               8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            npulse = int'(status_valid) + int'(crc_error) + int'(frame_error);
            if (npulse != 0) begin
                chk("onehot", 64'(npulse), 64'd1);
                if (exp_q.size() == 0) begin
                    total_n++;
                    $display("FAIL unexpected_pulse: got %b at cyc %0d want none",
                             {frame_error, crc_error, status_valid}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind", 64'({frame_error, crc_error, status_valid}),
                        64'(e.kind));
                    chk("cycle", 64'(cyc), 64'(e.cyc));
                    chk("id", 64'(status_id), 64'(e.id));
                    chk("error", 64'(status_error), 64'(e.err));
                    chk("data", 64'(status_data), 64'(e.data));
                    chk("count", 64'(status_param_count), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        pass_n   = 0;
        total_n  = 0;
        cyc      = 0;
        h_id     = '0;
        h_err    = '0;
        h_data   = '0;
        h_cnt    = '0;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #23;
        chk("rst_id", 64'(status_id), 64'd0);
        chk("rst_err", 64'(status_error), 64'd0);
        chk("rst_data", 64'(status_data), 64'd0);
        chk("rst_cnt", 64'(status_param_count), 64'd0);
        chk("rst_pulses", 64'({status_valid, crc_error, frame_error}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // ping reply, then a corrupted copy back to back
        load_ping();
        send_tx();
        push_ok(8'h01, 8'h00, 32'h0026_0406, 8'd3);
        load_ping();
        tx[13] = 8'h5E;
        send_tx();
        push_ev(K_CRC, cyc);
        idle(3);

        // noise with an extended FF preamble before a good packet
        tx = '{8'h12, 8'hFF, 8'h34, 8'hFF};
        send_tx();
        load_ping();
        send_tx();
        push_ok(8'h01, 8'h00, 32'h0026_0406, 8'd3);
        idle(3);

        // stuffed FD inside the payload
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h03, 8'h09, 8'h00,
               8'h55, 8'h04, 8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h22};
        begin
            logic [15:0] c;
            c = ref_crc(tx);
            tx.push_back(c[7:0]);
            tx.push_back(c[15:8]);
        end
        send_tx();
        push_ok(8'h03, 8'h04, 32'h22FD_FFFF, 8'd4);
        idle(3);

        // oversize LENGTH
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h20, 8'h00};
        send_tx();
        push_ev(K_FRM, cyc);
        idle(3);

        // wrong instruction
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h56};
        send_tx();
        push_ev(K_FRM, cyc);
        idle(3);

        // stall after ERR, then a full packet
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00,
               8'h55, 8'h00};
        send_tx();
        push_ev(K_FRM, cyc + TMO);
        idle(TMO + 5);
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h07, 8'h07, 8'h00,
               8'h55, 8'h00, 8'h06, 8'h04, 8'h26};
        begin
            logic [15:0] c;
            c = ref_crc(tx);
            tx.push_back(c[7:0]);
            tx.push_back(c[15:8]);
        end
        send_tx();
        push_ok(8'h07, 8'h00, 32'h0026_0406, 8'd3);
        idle(3);

        // reset in the middle of the payload
        tx = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00,
               8'h55, 8'h00, 8'h06};
        send_tx();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_id", 64'(status_id), 64'd0);
        chk("mid_rst_data", 64'(status_data), 64'd0);
        chk("mid_rst_cnt", 64'(status_param_count), 64'd0);
        chk("mid_rst_pulses",
            64'({status_valid, crc_error, frame_error}), 64'd0);
        h_id   = '0;
        h_err  = '0;
        h_data = '0;
        h_cnt  = '0;
        #20;
        reset_n = 1'b1;
        idle(2);
        load_ping();
        send_tx();
        push_ok(8'h01, 8'h00, 32'h0026_0406, 8'd3);
        idle(5);

        chk("pending_events", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
